// File: rtl/endec_rx_framer_pkg.sv
// Shared constants, config-word layout and FSM state type for the endec upstream framer.
package endec_rx_framer_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned POLY_W    = 27;
    localparam int unsigned FRAME_W   = 384;
    localparam int unsigned ENC_WORDS = 4;
    localparam int unsigned DEC_WORDS = 12;
    localparam int unsigned ENC_BITS  = ENC_WORDS * DATA_W;
    localparam int unsigned CNT_W     = 4;

    localparam int unsigned MODE_BIT = 29;
    localparam int unsigned RATE_BIT = 28;
    localparam int unsigned CLEN_BIT = 27;
    localparam int unsigned POLY_MSB = 26;

    localparam logic ENCODE_MODE = 1'b1;
    localparam logic DECODE_MODE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONF = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [1:0]        rsvd;
        logic              mode;
        logic              rate;
        logic              clen;
        logic [POLY_W-1:0] poly;
    } cfg_word_t;

    function automatic logic [DATA_W-1:0] pack_cfg(
        input logic              mode,
        input logic              rate,
        input logic              clen,
        input logic [POLY_W-1:0] poly
    );
        cfg_word_t c;
        c.rsvd = 2'b00;
        c.mode = mode;
        c.rate = rate;
        c.clen = clen;
        c.poly = poly;
        return DATA_W'(c);
    endfunction

endpackage

// File: rtl/endec_word_serializer.sv
// Frame shift register and word down-counter; presents the next word to send and whether it is last.
module endec_word_serializer
    import endec_rx_framer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               encode_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               pop_i,
    output logic [DATA_W-1:0]  head_word_c_o,
    output logic               head_last_c_o
);

    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Encode frames are left-aligned so both modes drain from the top word.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            if (encode_i) begin
                sreg_d = {frame_i[ENC_BITS-1:0], {(FRAME_W-ENC_BITS){1'b0}}};
                cnt_d  = CNT_W'(ENC_WORDS);
            end else begin
                sreg_d = frame_i;
                cnt_d  = CNT_W'(DEC_WORDS);
            end
        end else if (pop_i) begin
            sreg_d = sreg_q << DATA_W;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_word_c_o = sreg_q[FRAME_W-1 -: DATA_W];
    assign head_last_c_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/endec_rx_framer.sv
// Turns one accepted job into a 1-word config packet followed by its data packet on AXI-Stream.
module endec_rx_framer
    import endec_rx_framer_pkg::*;
(
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic               job_mode,
    input  logic               job_code_rate,
    input  logic               job_constr_len,
    input  logic [POLY_W-1:0]  job_gen_poly,
    input  logic [FRAME_W-1:0] job_data,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               frame_done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              done_q, done_d;
    logic              load_c, pop_c, xfer_c;
    logic [DATA_W-1:0] head_word_c;
    logic              head_last_c;

    assign xfer_c    = tvalid_q && m_axis_tready;
    assign job_ready = (state_q == ST_IDLE);

    // The job frame is captured into the serializer at accept, so job inputs are never re-sampled.
    endec_word_serializer u_ser (
        .clk_i         (sys_clk),
        .rst_i         (rst),
        .load_i        (load_c),
        .encode_i      (job_mode == ENCODE_MODE),
        .frame_i       (job_data),
        .pop_i         (pop_c),
        .head_word_c_o (head_word_c),
        .head_last_c_o (head_last_c)
    );

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        load_c   = 1'b0;
        pop_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    load_c   = 1'b1;
                    tdata_d  = pack_cfg(job_mode, job_code_rate, job_constr_len, job_gen_poly);
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    state_d  = ST_CONF;
                end
            end
            ST_CONF: begin
                if (xfer_c) begin
                    pop_c   = 1'b1;
                    tdata_d = head_word_c;
                    tlast_d = head_last_c;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_c) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        pop_c   = 1'b1;
                        tdata_d = head_word_c;
                        tlast_d = head_last_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_endec_rx_framer.sv
// Table-driven jobs with a word scoreboard, plus stall, held-valid and mid-packet reset sequences.
module tb_endec_rx_framer;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid, job_ready, job_mode, job_code_rate, job_constr_len;
    logic [26:0]  job_gen_poly;
    logic [383:0] job_data;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast, frame_done;

    always #5 clk = ~clk;

    endec_rx_framer dut (
        .sys_clk        (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_mode       (job_mode),
        .job_code_rate  (job_code_rate),
        .job_constr_len (job_constr_len),
        .job_gen_poly   (job_gen_poly),
        .job_data       (job_data),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .frame_done     (frame_done)
    );

    typedef struct {
        logic         mode;
        logic         rate;
        logic         clen;
        logic [26:0]  poly;
        logic [383:0] data;
        logic [31:0]  cfg;
    } job_t;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        is_cfg;
        logic        is_end;
    } item_t;

    job_t  jobs [4];
    item_t sbq[$];
    int    total = 0;
    int    bad = 0;
    int    done_cnt = 0;
    int    pop_cnt = 0;
    int    cyc = 0;
    int    cfg_cyc = 0;
    int    span = -1;
    int    tready_mode = 0;
    logic  tready_fix = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int idx);
        item_t        it;
        logic [383:0] d;
        int           n;
        d = jobs[idx].data;
        n = jobs[idx].mode ? 4 : 12;
        it.d = jobs[idx].cfg; it.l = 1'b1; it.is_cfg = 1'b1; it.is_end = 1'b0;
        sbq.push_back(it);
        for (int i = 0; i < n; i++) begin
            it.d      = d[32*n-1-32*i -: 32];
            it.l      = (i == n - 1);
            it.is_cfg = 1'b0;
            it.is_end = (i == n - 1);
            sbq.push_back(it);
        end
    endtask

    task automatic run_job(input int idx);
        job_mode       = jobs[idx].mode;
        job_code_rate  = jobs[idx].rate;
        job_constr_len = jobs[idx].clen;
        job_gen_poly   = jobs[idx].poly;
        job_data       = jobs[idx].data;
        job_valid      = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (job_ready) begin
                push_job(idx);
                tick();
                job_valid = 1'b0;
                return;
            end
            tick();
        end
        total++; bad++;
        $display("FAIL accept_timeout: got job_ready=0 want 1");
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_cnt;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done_cnt != start) return;
        end
        total++; bad++;
        $display("FAIL done_timeout: got frame_done count %0d want %0d", done_cnt, start + 1);
        sbq.delete();
    endtask

    // tready driver: fixed level or 50% random.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = (tready_mode == 1) ? 1'($urandom_range(0, 1)) : tready_fix;
        end
    end

    // Output monitor: scoreboard pop on handshake, hold-stability and frame_done timing.
    initial begin
        item_t       it;
        logic        stall = 1'b0;
        logic        exp_done = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall    = 1'b0;
                exp_done = 1'b0;
            end else begin
                if (exp_done || frame_done) check("frame_done", 64'(frame_done), 64'(exp_done));
                if (frame_done) done_cnt++;
                exp_done = 1'b0;
                if (stall)
                    check("stall_hold", {31'b0, m_axis_tvalid, m_axis_tdata, m_axis_tlast},
                          {31'b0, 1'b1, held_d, held_l});
                if (m_axis_tvalid && m_axis_tready) begin
                    pop_cnt++;
                    if (sbq.size() == 0) begin
                        check("unexpected_word", 64'(m_axis_tdata), 64'hDEAD_0000_0000);
                    end else begin
                        it = sbq.pop_front();
                        check("word", {31'b0, m_axis_tdata, m_axis_tlast}, {31'b0, it.d, it.l});
                        if (it.is_cfg) cfg_cyc = cyc;
                        if (it.is_end) begin
                            exp_done = 1'b1;
                            span     = cyc - cfg_cyc;
                        end
                    end
                end
                stall  = m_axis_tvalid && !m_axis_tready;
                held_d = m_axis_tdata;
                held_l = m_axis_tlast;
            end
        end
    end

    initial begin
        logic [383:0] ramp;
        int           d0;
        for (int i = 0; i < 12; i++) ramp[383-32*i -: 32] = 32'h1000_0000 + 32'(i);

        jobs[0] = '{mode: 1'b1, rate: 1'b1, clen: 1'b0, poly: 27'h5A5A5A5,
                    data: {{8{32'hA5A5_0F0F}}, 128'h00112233_44556677_8899AABB_CCDDEEFF},
                    cfg: 32'h35A5_A5A5};
        jobs[1] = '{mode: 1'b0, rate: 1'b0, clen: 1'b1, poly: 27'h7FFFFFF,
                    data: ramp, cfg: 32'h0FFF_FFFF};
        jobs[2] = '{mode: 1'b1, rate: 1'b0, clen: 1'b1, poly: 27'h0000001,
                    data: {{8{32'hFFFF_0000}}, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF},
                    cfg: 32'h2800_0001};
        jobs[3] = '{mode: 1'b0, rate: 1'b1, clen: 1'b0, poly: 27'h1234567,
                    data: {12{32'h0BAD_F00D}} ^ {ramp[191:0], ramp[383:192]},
                    cfg: 32'h1123_4567};

        rst = 1'b1; job_valid = 1'b0; job_mode = 1'b0; job_code_rate = 1'b0;
        job_constr_len = 1'b0; job_gen_poly = '0; job_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {59'b0, m_axis_tvalid, m_axis_tlast, frame_done, job_ready, 1'b0},
              {59'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        check("reset_tdata", 64'(m_axis_tdata), 64'h0);
        rst = 1'b0;
        tick();

        // Every table job back to back at full rate, with consecutive-cycle span.
        for (int j = 0; j < 4; j++) begin
            run_job(j);
            wait_done(100);
            check("span", 64'(span), jobs[j].mode ? 64'd4 : 64'd12);
            check("idle_after_done", {62'b0, job_ready, m_axis_tvalid}, {62'b0, 1'b1, 1'b0});
        end

        // Random backpressure on a decode job.
        tready_mode = 1;
        run_job(3);
        wait_done(2000);
        tready_mode = 0;
        tick();

        // job_valid held through an encode job: second accept only after frame_done.
        job_mode = jobs[0].mode; job_code_rate = jobs[0].rate; job_constr_len = jobs[0].clen;
        job_gen_poly = jobs[0].poly; job_data = jobs[0].data;
        job_valid = 1'b1;
        push_job(0);
        tick();
        check("busy_ready", 64'(job_ready), 64'd0);
        wait_done(100);
        push_job(0);
        check("second_accept", {62'b0, job_ready, m_axis_tvalid}, {62'b0, 1'b0, 1'b1});
        job_valid = 1'b0;
        wait_done(100);
        tick();

        // Reset while data word 6 of a decode packet is presented.
        d0 = pop_cnt;
        run_job(1);
        for (int k = 0; k < 50 && (pop_cnt - d0) < 6; k++) tick();
        check("word6_present", 64'(m_axis_tdata), 64'(jobs[1].data[383-32*5 -: 32]));
        rst = 1'b1;
        sbq.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_packet", {60'b0, m_axis_tvalid, m_axis_tlast, job_ready, frame_done},
              {60'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tick();
        run_job(0);
        wait_done(100);

        // tready low for 100 cycles while the config word is offered.
        tready_fix = 1'b0;
        tick();
        d0 = done_cnt;
        run_job(2);
        repeat (100) tick();
        check("stall_cfg", {31'b0, m_axis_tvalid, m_axis_tdata, m_axis_tlast},
              {31'b0, 1'b1, jobs[2].cfg, 1'b1});
        check("stall_no_done", 64'(done_cnt), 64'(d0));
        tready_fix = 1'b1;
        wait_done(100);
        repeat (3) tick();

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
